instr_queue_reg: RTL and testbench

- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH fetched instructions in a FIFO, so memory fetch can run ahead of the control state machine.
- Presents the head instruction as a registered value, with an opcode field split out.
- Sits between instruction memory (producer) and the control FSM (consumer). A flush clears all entries on a branch or jump.

---
 rtl/instr_queue_reg.sv | 84 ++++++++
 tb/tb_instr_queue_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_reg.sv
// Instruction queue: DEPTH-entry FIFO between instruction memory and the control FSM.
// Optional sticky misuse flag on ovf_o enabled by defining IR_OVERFLOW_FLAG_EN.
module instr_queue_reg #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int OPW   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [W-1:0]               data_i,
   input  logic                       load_i,
   output logic                       in_ready_o,
   input  logic                       take_i,
   input  logic                       flush_i,
   output logic [W-1:0]               out_o,
   output logic [OPW-1:0]             opcode_o,
   output logic                       out_valid_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   assign push = load_i && (count_q < CW'(DEPTH));
   assign pop  = take_i && (count_q != '0);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is never reset; the count-based mask hides stale words.
   always_ff @(posedge clk) begin
      if (!flush_i && push) mem_q[wptr_q] <= data_i;
   end

   assign in_ready_o  = (count_q < CW'(DEPTH));
   assign out_valid_o = (count_q != '0);
   assign out_o       = out_valid_o ? mem_q[rptr_q] : '0;
   assign opcode_o    = out_o[W-1 -: OPW];
   assign count_o     = count_q;

`ifdef IR_OVERFLOW_FLAG_EN
   logic ovf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf_q <= 1'b0;
      else if (flush_i) ovf_q <= 1'b0;
      else if ((load_i && !in_ready_o) || (take_i && !out_valid_o))
         ovf_q <= 1'b1;
   end
   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_queue_reg.sv
// Self-checking bench for instr_queue_reg: queue-based reference model compared every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_instr_queue_reg;
   localparam int W = 16, DEPTH = 4, OPW = 4;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [W-1:0]  data = '0;
   logic          load = 1'b0, take = 1'b0, flush = 1'b0;
   logic          in_ready, out_valid, ovf;
   logic [W-1:0]  out;
   logic [OPW-1:0] opcode;
   logic [2:0]    count;

   int checks = 0;
   int errors = 0;

`ifdef IR_OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   instr_queue_reg #(.W(W), .DEPTH(DEPTH), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n), .data_i(data), .load_i(load), .in_ready_o(in_ready),
      .take_i(take), .flush_i(flush), .out_o(out), .opcode_o(opcode),
      .out_valid_o(out_valid), .count_o(count), .ovf_o(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue plus a sticky flag.
   logic [W-1:0] mq[$];
   bit           m_ovf = 1'b0;

   always @(negedge rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            bit full, empty;
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if ((load && full) || (take && empty)) m_ovf = OVF_EN;
            if (take && !empty) void'(mq.pop_front());
            if (load && !full)  mq.push_back(data);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e_out;
      e_out = (mq.size() != 0) ? mq[0] : '0;
      check("model_out",       32'(out),       32'(e_out));
      check("model_opcode",    32'(opcode),    32'(e_out[W-1 -: OPW]));
      check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("model_in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      check("model_count",     32'(count),     32'(mq.size()));
      check("model_ovf",       32'(ovf),       32'(m_ovf));
   end

   task automatic step(input logic l, input logic t, input logic f, input logic [W-1:0] d);
      load = l; take = t; flush = f; data = d;
      @(posedge clk);
      #1;
      load = 1'b0; take = 1'b0; flush = 1'b0;
   endtask

   initial begin
      #12;
      check("reset_out",       32'(out), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_in_ready",  32'(in_ready), 32'h1);
      check("reset_count",     32'(count), 32'h0);
      check("reset_ovf",       32'(ovf), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single load latency
      step(1, 0, 0, 16'hA123);
      check("first_out",    32'(out), 32'hA123);
      check("first_opcode", 32'(opcode), 32'hA);
      check("first_valid",  32'(out_valid), 32'h1);
      check("first_count",  32'(count), 32'h1);
      step(0, 1, 0, '0);

      // Fill, overflow drop, drain in order
      for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'(16'h1000 + i));
      check("full_count",    32'(count), 32'h4);
      check("full_in_ready", 32'(in_ready), 32'h0);
      step(1, 0, 0, 16'h1005);
      check("drop_count", 32'(count), 32'h4);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", 32'(out), 32'(16'h1000 + i));
         step(0, 1, 0, '0);
      end
      check("drained_valid", 32'(out_valid), 32'h0);
      check("drained_out",   32'(out), 32'h0);

      // Empty: load+take pushes only
      step(1, 1, 0, 16'h3333);
      check("empty_lt_count", 32'(count), 32'h1);
      check("empty_lt_out",   32'(out), 32'h3333);

      // Steady state with pointer wrap
      step(1, 0, 0, 16'h2000);
      for (int i = 1; i <= 10; i++) begin
         step(1, 1, 0, 16'(16'h2000 + i));
         check("wrap_count", 32'(count), 32'h2);
         check("wrap_head",  32'(out), (i == 1) ? 32'h2000 : 32'(16'h2000 + i - 1));
      end

      // Full with load+take: pop only, BEEF dropped
      step(0, 0, 1, '0);
      for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'(16'h4000 + i));
      step(1, 1, 0, 16'hBEEF);
      check("full_lt_count", 32'(count), 32'h3);
      for (int i = 0; i < 3; i++) begin
         check("no_beef", 32'(out != 16'hBEEF), 32'h1);
         step(0, 1, 0, '0);
      end
      check("no_beef_empty", 32'(out_valid), 32'h0);

      // Flush beats load
      for (int i = 1; i <= 3; i++) step(1, 0, 0, 16'(16'h5000 + i));
      step(1, 0, 1, 16'h5555);
      check("flush_count",    32'(count), 32'h0);
      check("flush_valid",    32'(out_valid), 32'h0);
      check("flush_in_ready", 32'(in_ready), 32'h1);

      // Asynchronous reset mid-cycle with count=2
      step(1, 0, 0, 16'h6001);
      step(1, 0, 0, 16'h6002);
      check("pre_rst_count", 32'(count), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out",   32'(out), 32'h0);
      check("async_rst_valid", 32'(out_valid), 32'h0);
      check("async_rst_count", 32'(count), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Misuse flag
      step(0, 1, 0, '0);
      for (int i = 0; i < 5; i++) begin
         check("ovf_sticky", 32'(ovf), 32'(OVF_EN));
         step(0, 0, 0, '0);
      end
      step(0, 0, 1, '0);
      check("ovf_flush", 32'(ovf), 32'h0);
      step(0, 1, 1, '0);
      check("ovf_flush_wins", 32'(ovf), 32'h0);

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
